// File: rtl/wb_rambus_arbiter.sv
// Round-robin two-master Wishbone arbiter for the OpenRAM rambus port, with a per-transfer watchdog.
// Grant one cycle after request, no data-path stage; the losing master stalls (no ack) until the owner drops cyc.
module wb_rambus_arbiter #(
  parameter int          ADDR_WIDTH   = 10,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [31:0]           m0_dat_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  output logic                  m0_ack_o,
  output logic [31:0]           m0_dat_o,
  input  logic                  m1_stb_i,
  input  logic                  m1_cyc_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [31:0]           m1_dat_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  output logic                  m1_ack_o,
  output logic [31:0]           m1_dat_o,
  output logic                  rambus_wb_clk_o,
  output logic                  rambus_wb_rst_o,
  output logic                  rambus_wb_stb_o,
  output logic                  rambus_wb_cyc_o,
  output logic                  rambus_wb_we_o,
  output logic [3:0]            rambus_wb_sel_o,
  output logic [31:0]           rambus_wb_dat_o,
  output logic [ADDR_WIDTH-1:0] rambus_wb_adr_o,
  input  logic                  rambus_wb_ack_i,
  input  logic [31:0]           rambus_wb_dat_i,
  input  logic                  timeout_clr_i,
  output logic                  timeout_o,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  state_t      state;
  logic        last;
  logic [9:0]  wd;
  logic        req0;
  logic        req1;
  logic        own_cyc;
  logic        own_stb;
  logic        fire;

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_n_i;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_comb begin
    own_cyc         = 1'b0;
    own_stb         = 1'b0;
    rambus_wb_we_o  = 1'b0;
    rambus_wb_sel_o = 4'h0;
    rambus_wb_dat_o = 32'h0;
    rambus_wb_adr_o = '0;
    case (state)
      GNT0: begin
        own_cyc         = m0_cyc_i;
        own_stb         = m0_stb_i;
        rambus_wb_we_o  = m0_we_i;
        rambus_wb_sel_o = m0_sel_i;
        rambus_wb_dat_o = m0_dat_i;
        rambus_wb_adr_o = m0_adr_i;
      end
      GNT1: begin
        own_cyc         = m1_cyc_i;
        own_stb         = m1_stb_i;
        rambus_wb_we_o  = m1_we_i;
        rambus_wb_sel_o = m1_sel_i;
        rambus_wb_dat_o = m1_dat_i;
        rambus_wb_adr_o = m1_adr_i;
      end
      default: ;
    endcase
    // Watchdog expiry withdraws the request from the slave and acks the master in the same cycle.
    fire            = (state != IDLE) && own_stb && !rambus_wb_ack_i && (wd == WD_LAST);
    rambus_wb_cyc_o = own_cyc & ~fire;
    rambus_wb_stb_o = own_stb & ~fire;
    m0_ack_o        = (state == GNT0) && (rambus_wb_ack_i || fire);
    m1_ack_o        = (state == GNT1) && (rambus_wb_ack_i || fire);
    m0_dat_o        = (state != GNT0) ? 32'h0 : (fire ? TIMEOUT_DATA : rambus_wb_dat_i);
    m1_dat_o        = (state != GNT1) ? 32'h0 : (fire ? TIMEOUT_DATA : rambus_wb_dat_i);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      last      <= 1'b1;
      wd        <= 10'd0;
      timeout_o <= 1'b0;
      grant_o   <= 2'b00;
    end else begin
      if (fire) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          wd <= 10'd0;
          // On a tie the master that was not granted last time wins.
          if (req0 && (!req1 || last)) begin
            state   <= GNT0;
            last    <= 1'b0;
            grant_o <= 2'b01;
          end else if (req1) begin
            state   <= GNT1;
            last    <= 1'b1;
            grant_o <= 2'b10;
          end
        end
        GNT0, GNT1: begin
          if (fire || !own_cyc) begin
            state   <= IDLE;
            grant_o <= 2'b00;
            wd      <= 10'd0;
          end else if (rambus_wb_ack_i || !own_stb) begin
            wd <= 10'd0;
          end else begin
            wd <= wd + 10'd1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
          wd      <= 10'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rambus_arbiter.sv
// Bench for wb_rambus_arbiter: directed transfers, scoreboard of expected acks and grant order.
module tb_wb_rambus_arbiter;

  typedef struct {
    int          m;
    logic [31:0] dat;
    int          lat;
    logic        stb;
  } ack_exp_t;

  typedef struct {
    logic [1:0] g;
    int         gap;
  } gnt_exp_t;

  logic        clk;
  logic        rst_n;
  logic        m0_stb, m0_cyc, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_wdat;
  logic [9:0]  m0_adr;
  logic        m0_ack_o;
  logic [31:0] m0_dat_o;
  logic        m1_stb, m1_cyc, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_wdat;
  logic [9:0]  m1_adr;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        rb_clk, rb_rst, rb_stb, rb_cyc, rb_we;
  logic [3:0]  rb_sel;
  logic [31:0] rb_wdat;
  logic [9:0]  rb_adr;
  logic        rb_ack;
  logic [31:0] rb_rdat;
  logic        timeout_clr;
  logic        timeout_o;
  logic [1:0]  grant_o;

  logic        s_ack;
  logic [31:0] s_dat;
  logic        late_ack;
  bit          hang;

  int vectors;
  int miscompares;

  ack_exp_t exp_q[$];
  gnt_exp_t gnt_q[$];

  assign rb_ack  = s_ack | late_ack;
  assign rb_rdat = s_dat;

  wb_rambus_arbiter #(.ADDR_WIDTH(10), .TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_dat_i(m0_wdat), .m0_adr_i(m0_adr), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_dat_i(m1_wdat), .m1_adr_i(m1_adr), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .rambus_wb_clk_o(rb_clk), .rambus_wb_rst_o(rb_rst),
    .rambus_wb_stb_o(rb_stb), .rambus_wb_cyc_o(rb_cyc), .rambus_wb_we_o(rb_we),
    .rambus_wb_sel_o(rb_sel), .rambus_wb_dat_o(rb_wdat), .rambus_wb_adr_o(rb_adr),
    .rambus_wb_ack_i(rb_ack), .rambus_wb_dat_i(rb_rdat),
    .timeout_clr_i(timeout_clr), .timeout_o(timeout_o), .grant_o(grant_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic push_ack(input int m, input logic [31:0] d, input int lat, input logic stb);
    ack_exp_t e;
    e.m = m; e.dat = d; e.lat = lat; e.stb = stb;
    exp_q.push_back(e);
  endtask

  task automatic push_gnt(input logic [1:0] g, input int gap);
    gnt_exp_t e;
    e.g = g; e.gap = gap;
    gnt_q.push_back(e);
  endtask

  task automatic drive(input int m, input logic c, input logic s, input logic w,
                       input logic [9:0] a, input logic [31:0] d, input logic [3:0] sl);
    if (m == 0) begin
      m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_wdat = d; m0_sel = sl;
    end else begin
      m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_wdat = d; m1_sel = sl;
    end
  endtask

  task automatic wait_ack(input int m, input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ack_o : m1_ack_o;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: ack never arrived within 60 cycles, required ack=1", nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int m, input logic w, input logic [9:0] a, input logic [31:0] d, input string nm);
    @(posedge clk);
    #1;
    drive(m, 1'b1, 1'b1, w, a, d, 4'hF);
    wait_ack(m, nm);
    drive(m, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
  endtask

  task automatic block_read(input int m, input int n, input string nm);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      drive(m, 1'b1, 1'b1, 1'b0, 10'(i), 32'h0, 4'hF);
      wait_ack(m, nm);
    end
    drive(m, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
  endtask

  task automatic check_all_quiet(input string nm);
    check({nm, "_rambus"}, {rb_stb, rb_cyc, rb_we, rb_sel, rb_adr, rb_wdat}, 64'h0);
    check({nm, "_masters"}, {m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o}, 64'h0);
    check({nm, "_flags"}, {grant_o, timeout_o, rb_rst}, 64'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_quiet("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Slave: acks on the third cycle a request is held (two wait cycles), unless hung.
  initial begin
    logic        req;
    logic        active;
    logic        we_s;
    logic [9:0]  adr_s;
    logic [31:0] wd_s;
    int          scnt;
    s_ack = 1'b0;
    s_dat = 32'h0;
    scnt  = 0;
    forever begin
      @(negedge clk);
      active = rb_stb && rb_cyc;
      req    = active && !rb_ack;
      we_s   = rb_we;
      adr_s  = rb_adr;
      wd_s   = rb_wdat;
      @(posedge clk);
      #1;
      if (req && !hang && scnt == 1) begin
        s_ack = 1'b1;
        s_dat = we_s ? ~wd_s : (32'hC0DE_0000 | {22'h0, adr_s});
        scnt  = 0;
      end else begin
        s_ack = 1'b0;
        s_dat = 32'h0;
        if (req) scnt++;
        else if (!active) scnt = 0;
      end
    end
  end

  // Monitor: pops grant and ack expectations as the DUT presents them.
  initial begin
    logic [1:0]  prev_g;
    int          idle;
    int          gcyc;
    gnt_exp_t    ge;
    ack_exp_t    ae;
    int          am;
    logic [31:0] adat;
    logic [31:0] odat;
    prev_g = 2'b00;
    idle   = 0;
    gcyc   = 0;
    forever begin
      @(negedge clk);
      if (grant_o != 2'b00 && grant_o != prev_g) begin
        vectors++;
        if (gnt_q.size() == 0) begin
          miscompares++;
          $display("FAIL grant_unexpected: got grant %b, required no grant", grant_o);
        end else begin
          ge = gnt_q.pop_front();
          if (grant_o !== ge.g || (ge.gap >= 0 && idle != ge.gap)) begin
            miscompares++;
            $display("FAIL grant_order: got %b after %0d idle cycles, required %b after %0d",
                     grant_o, idle, ge.g, ge.gap);
          end
        end
        gcyc = 1;
      end else if (grant_o != 2'b00) begin
        gcyc++;
      end
      if (grant_o == 2'b00) idle = (prev_g != 2'b00) ? 1 : idle + 1;
      prev_g = grant_o;
      if (m0_ack_o || m1_ack_o) begin
        vectors++;
        am   = m1_ack_o ? 1 : 0;
        adat = am ? m1_dat_o : m0_dat_o;
        odat = am ? m0_dat_o : m1_dat_o;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL ack_unexpected: got ack on m%0d data %h, required no ack", am, adat);
        end else begin
          ae = exp_q.pop_front();
          if ((m0_ack_o && m1_ack_o) || am != ae.m || adat !== ae.dat || odat !== 32'h0 ||
              rb_stb !== ae.stb || (ae.lat >= 0 && gcyc != ae.lat)) begin
            miscompares++;
            $display("FAIL ack_check: got m%0d dat %h other %h stb %b cycle %0d, required m%0d dat %h other 0 stb %b cycle %0d",
                     am, adat, odat, rb_stb, gcyc, ae.m, ae.dat, ae.stb, ae.lat);
          end
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    hang        = 1'b0;
    late_ack    = 1'b0;
    timeout_clr = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    #3 check_all_quiet("por");
    #19 rst_n = 1'b1;

    // Single m0 write, slave latency 2.
    push_gnt(2'b01, -1);
    push_ack(0, 32'h5A5A_FFFE, 3, 1'b1);
    fork
      xfer(0, 1'b1, 10'h010, 32'hA5A5_0001, "m0_write");
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("fwd_req", {rb_stb, rb_cyc, rb_we, rb_sel, rb_adr, rb_wdat},
              {15'h0, 1'b1, 1'b1, 1'b1, 4'hF, 10'h010, 32'hA5A5_0001});
      end
    join
    repeat (2) @(negedge clk);
    check("grant_release", grant_o, 2'b00);

    // Contested requests from reset alternate 01,10,01,10 with one idle cycle each.
    do_reset();
    push_gnt(2'b01, -1); push_gnt(2'b10, 1); push_gnt(2'b01, 1); push_gnt(2'b10, 1);
    push_ack(0, 32'hC0DE_0100, 3, 1'b1); push_ack(1, 32'hC0DE_0200, 3, 1'b1);
    push_ack(0, 32'hC0DE_0101, 3, 1'b1); push_ack(1, 32'hC0DE_0201, 3, 1'b1);
    fork
      xfer(0, 1'b0, 10'h100, 32'h0, "cont_m0_a");
      xfer(1, 1'b0, 10'h200, 32'h0, "cont_m1_a");
    join
    fork
      xfer(0, 1'b0, 10'h101, 32'h0, "cont_m0_b");
      xfer(1, 1'b0, 10'h201, 32'h0, "cont_m1_b");
    join

    // m1 block read of four words holds off m0 until cyc drops.
    push_gnt(2'b10, -1); push_gnt(2'b01, 1);
    push_ack(1, 32'hC0DE_0000, 3, 1'b1); push_ack(1, 32'hC0DE_0001, 6, 1'b1);
    push_ack(1, 32'hC0DE_0002, 9, 1'b1); push_ack(1, 32'hC0DE_0003, 12, 1'b1);
    push_ack(0, 32'hC0DE_0020, 3, 1'b1);
    fork
      block_read(1, 4, "block_m1");
      begin
        repeat (2) @(posedge clk);
        xfer(0, 1'b0, 10'h020, 32'h0, "block_m0");
      end
    join

    // Hung slave: synthetic ack in cycle 8, sticky flag, late ack ignored, then clear.
    hang = 1'b1;
    push_gnt(2'b01, -1);
    push_ack(0, 32'hDEAD_BEEF, 8, 1'b0);
    xfer(0, 1'b0, 10'h005, 32'h0, "hung_m0");
    check("timeout_set", timeout_o, 1'b1);
    repeat (3) @(negedge clk);
    check("timeout_held", {grant_o, timeout_o}, 3'b001);
    @(posedge clk);
    #1 late_ack = 1'b1;
    @(negedge clk);
    check("late_ack_ignored", {m0_ack_o, m1_ack_o, grant_o}, 4'b0000);
    @(posedge clk);
    #1 late_ack = 1'b0;
    @(negedge clk);
    check("late_ack_idle", grant_o, 2'b00);
    @(posedge clk);
    #1 timeout_clr = 1'b1;
    @(posedge clk);
    #1 timeout_clr = 1'b0;
    @(negedge clk);
    check("timeout_clr", timeout_o, 1'b0);

    // Reset while m0 owns the bus with a stalled strobe.
    push_gnt(2'b01, -1);
    @(posedge clk);
    #1 drive(0, 1'b1, 1'b1, 1'b1, 10'h033, 32'h1234_5678, 4'h3);
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_fwd", {rb_stb, rb_adr}, {1'b1, 10'h033});
    #2 rst_n = 1'b0;
    #1 check_all_quiet("mid_reset");
    drive(0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    hang = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    push_gnt(2'b01, -1); push_gnt(2'b10, 1);
    push_ack(0, 32'hC0DE_0040, 3, 1'b1); push_ack(1, 32'hC0DE_0041, 3, 1'b1);
    fork
      xfer(0, 1'b0, 10'h040, 32'h0, "post_reset_m0");
      xfer(1, 1'b0, 10'h041, 32'h0, "post_reset_m1");
    join

    repeat (3) @(negedge clk);
    check("ack_queue_drained", exp_q.size(), 0);
    check("grant_queue_drained", gnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
